// File: rtl/ctx_pkg.sv
// ctx_pkg: shared state encoding and transfer-direction constants for reg_ctx_engine
package ctx_pkg;
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    localparam logic DIR_SPILL = 1'b0;
    localparam logic DIR_FILL  = 1'b1;
endpackage

// File: rtl/reg_ctx_engine.sv
// reg_ctx_engine: register-context spill/fill engine, one byte per cycle between register file and data memory
// Ports: clk, reset_n (sync, active-low); start/dir/base_addr/first_reg/count request (latched in IDLE);
//   stall freezes the current cycle; rf_* register-file read/write port; mem_* data-memory port;
//   busy (XFER), done (one-cycle pulse), checksum (XOR of moved bytes).
// Optional: CTX_CHECKSUM_EN builds the checksum accumulator; otherwise checksum is 8'h00.
module reg_ctx_engine
    import ctx_pkg::*;
#(
    parameter int pw = 4,
    parameter int aw = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          dir,
    input  logic [aw-1:0] base_addr,
    input  logic [pw-1:0] first_reg,
    input  logic [pw:0]   count,
    input  logic          stall,
    output logic [pw-1:0] rf_rd_addr,
    input  logic [7:0]    rf_rd_dat,
    output logic          rf_wr_en,
    output logic [pw-1:0] rf_wr_addr,
    output logic [7:0]    rf_wr_dat,
    output logic [aw-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat,
    output logic          busy,
    output logic          done,
    output logic [7:0]    checksum
);
    state_t        state_q, state_d;
    logic [pw-1:0] idx_q;
    logic [aw-1:0] addr_q;
    logic [pw:0]   rem_q;
    logic          dir_q;
    logic          accept, xfer;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        accept     = (state_q == IDLE) && start;
        xfer       = (state_q == XFER) && !stall;
        state_d    = state_q == IDLE ? (start ? (count != '0 ? XFER : DONE) : IDLE)
                   : state_q == XFER ? (xfer && rem_q == (pw+1)'(1) ? DONE : XFER)
                   : IDLE;
        busy       = state_q == XFER;
        done       = state_q == DONE;
        rf_rd_addr = state_q == IDLE ? '0 : idx_q;
        rf_wr_addr = rf_rd_addr;
        mem_addr   = state_q == IDLE ? '0 : addr_q;
        mem_wr_en  = xfer && dir_q == DIR_SPILL;
        rf_wr_en   = xfer && dir_q == DIR_FILL;
        mem_wr_dat = mem_wr_en ? rf_rd_dat : 8'h00;
        rf_wr_dat  = rf_wr_en ? mem_rd_dat : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q  <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            dir_q  <= DIR_SPILL;
        end else if (accept) begin
            idx_q  <= first_reg;
            addr_q <= base_addr;
            rem_q  <= count;
            dir_q  <= dir;
        end else if (xfer) begin
            idx_q  <= idx_q + 1'b1;
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
        end
    end

`ifdef CTX_CHECKSUM_EN
    logic [7:0] cs_q;
    // The moved byte is whatever is being read on the source side this cycle.
    always_ff @(posedge clk) begin
        if (!reset_n)    cs_q <= 8'h00;
        else if (accept) cs_q <= 8'h00;
        else if (xfer)   cs_q <= cs_q ^ (dir_q == DIR_FILL ? mem_rd_dat : rf_rd_dat);
    end
    assign checksum = cs_q;
`else
    assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_reg_ctx_engine.sv
// tb_reg_ctx_engine: directed self-checking bench with register-file and memory models around reg_ctx_engine
module tb_reg_ctx_engine;
`ifdef CTX_CHECKSUM_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [3:0] first_reg = 4'h0;
    logic [4:0] count = 5'd0;
    logic       stall = 1'b0;
    logic [3:0] rf_rd_addr, rf_wr_addr;
    logic [7:0] rf_rd_dat, rf_wr_dat, mem_wr_dat, mem_rd_dat, checksum;
    logic [7:0] mem_addr;
    logic       rf_wr_en, mem_wr_en, busy, done;

    logic [7:0] regs [16];
    logic [7:0] mem  [256];
    int         mem_wr_cnt = 0;
    int         rf_wr_cnt  = 0;
    logic       pl_en = 1'b0;
    logic       pl_mem = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_dat = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_ctx_engine #(.pw(4), .aw(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dir(dir),
        .base_addr(base_addr), .first_reg(first_reg), .count(count), .stall(stall),
        .rf_rd_addr(rf_rd_addr), .rf_rd_dat(rf_rd_dat), .rf_wr_en(rf_wr_en),
        .rf_wr_addr(rf_wr_addr), .rf_wr_dat(rf_wr_dat), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_dat(mem_wr_dat), .mem_rd_dat(mem_rd_dat),
        .busy(busy), .done(done), .checksum(checksum)
    );

    assign rf_rd_dat  = regs[rf_rd_addr];
    assign mem_rd_dat = mem[mem_addr];

    // Storage models take writes mid-cycle; write data is stable for the whole cycle.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_dat;
            mem_wr_cnt = mem_wr_cnt + 1;
        end
        if (rf_wr_en) begin
            regs[rf_wr_addr] = rf_wr_dat;
            rf_wr_cnt = rf_wr_cnt + 1;
        end
        if (pl_en) begin
            if (pl_mem) mem[pl_addr] = pl_dat;
            else        regs[pl_addr[3:0]] = pl_dat;
        end
    end

    task automatic preload(input logic is_mem, input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_mem = is_mem; pl_addr = a; pl_dat = d;
        @(negedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_op(input logic d, input logic [3:0] fr, input logic [4:0] cnt,
                          input logic [7:0] base, input int stall_at,
                          output int busy_n, output int done_at, output int stall_wr,
                          output int wr_n, output logic [7:0] cs);
        int wr0;
        busy_n = 0; done_at = 0; stall_wr = 0; cs = 8'hxx;
        @(posedge clk); #1;
        wr0 = mem_wr_cnt + rf_wr_cnt;
        dir = d; first_reg = fr; count = cnt; base_addr = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            stall = (c == stall_at);
            #1;
            if (busy) busy_n++;
            if (c == stall_at && (mem_wr_en || rf_wr_en)) stall_wr++;
            if (done) begin
                done_at = c;
                cs = checksum;
                break;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(posedge clk); #1;
        wr_n = mem_wr_cnt + rf_wr_cnt - wr0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({rf_wr_en, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_we got=%b exp=00", {rf_wr_en, mem_wr_en}); end
        checks++; if (mem_addr !== 8'h00 || rf_rd_addr !== 4'h0 || rf_wr_addr !== 4'h0) begin errors++; $display("FAIL reset_addr got=%h/%h/%h exp=0", mem_addr, rf_rd_addr, rf_wr_addr); end
        checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum got=%h exp=00", checksum); end
        reset_n = 1'b1;
    endtask

    task automatic test_spill();
        int b, da, sw, wn;
        logic [7:0] cs;
        logic [7:0] exp_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            preload(1'b0, 8'(2 + i), exp_v[i]);
            preload(1'b1, 8'(8'h40 + i), 8'h00);
        end
        run_op(1'b0, 4'd2, 5'd4, 8'h40, 0, b, da, sw, wn, cs);
        checks++; if (b != 4) begin errors++; $display("FAIL spill_busy got=%0d exp=4", b); end
        checks++; if (da != 5) begin errors++; $display("FAIL spill_done_cycle got=%0d exp=5", da); end
        checks++; if (wn != 4) begin errors++; $display("FAIL spill_writes got=%0d exp=4", wn); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[8'h40 + i] !== exp_v[i]) begin errors++; $display("FAIL spill_mem%0d got=%h exp=%h", i, mem[8'h40 + i], exp_v[i]); end
        end
        checks++; if (cs !== (CS_ON ? 8'h44 : 8'h00)) begin errors++; $display("FAIL spill_checksum got=%h exp=%h", cs, CS_ON ? 8'h44 : 8'h00); end
    endtask

    task automatic test_fill_wrap();
        int b, da, sw, wn;
        logic [7:0] cs;
        preload(1'b1, 8'h80, 8'hAA);
        preload(1'b1, 8'h81, 8'hBB);
        preload(1'b1, 8'h82, 8'hCC);
        preload(1'b0, 8'd15, 8'h00);
        preload(1'b0, 8'd0, 8'h00);
        preload(1'b0, 8'd1, 8'h00);
        run_op(1'b1, 4'd15, 5'd3, 8'h80, 0, b, da, sw, wn, cs);
        checks++; if (regs[15] !== 8'hAA) begin errors++; $display("FAIL fill_r15 got=%h exp=aa", regs[15]); end
        checks++; if (regs[0] !== 8'hBB) begin errors++; $display("FAIL fill_r0 got=%h exp=bb", regs[0]); end
        checks++; if (regs[1] !== 8'hCC) begin errors++; $display("FAIL fill_r1 got=%h exp=cc", regs[1]); end
        checks++; if (rf_wr_cnt < 3 || wn != 3) begin errors++; $display("FAIL fill_writes got=%0d exp=3", wn); end
        checks++; if (da != 4) begin errors++; $display("FAIL fill_done_cycle got=%0d exp=4", da); end
        checks++; if (cs !== (CS_ON ? 8'hDD : 8'h00)) begin errors++; $display("FAIL fill_checksum got=%h exp=%h", cs, CS_ON ? 8'hDD : 8'h00); end
    endtask

    task automatic test_stall();
        int b, da, sw, wn;
        logic [7:0] cs;
        preload(1'b0, 8'd6, 8'h5A);
        preload(1'b0, 8'd7, 8'hA5);
        preload(1'b1, 8'h50, 8'h00);
        preload(1'b1, 8'h51, 8'h00);
        run_op(1'b0, 4'd6, 5'd2, 8'h50, 1, b, da, sw, wn, cs);
        checks++; if (wn != 2) begin errors++; $display("FAIL stall_writes got=%0d exp=2", wn); end
        checks++; if (da != 4) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=4", da); end
        checks++; if (sw != 0) begin errors++; $display("FAIL stall_write_in_stall got=%0d exp=0", sw); end
        checks++; if (b != 3) begin errors++; $display("FAIL stall_busy got=%0d exp=3", b); end
        checks++; if (mem[8'h50] !== 8'h5A || mem[8'h51] !== 8'hA5) begin errors++; $display("FAIL stall_mem got=%h%h exp=5aa5", mem[8'h50], mem[8'h51]); end
    endtask

    task automatic test_count_zero();
        int b, da, sw, wn;
        logic [7:0] cs;
        run_op(1'b0, 4'd3, 5'd0, 8'h20, 0, b, da, sw, wn, cs);
        checks++; if (da != 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", da); end
        checks++; if (wn != 0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", wn); end
        checks++; if (b != 0) begin errors++; $display("FAIL zero_busy got=%0d exp=0", b); end
    endtask

    task automatic test_mem_wrap();
        int b, da, sw, wn;
        logic [7:0] cs;
        preload(1'b0, 8'd8, 8'h01);
        preload(1'b0, 8'd9, 8'h02);
        preload(1'b0, 8'd10, 8'h03);
        preload(1'b1, 8'hFE, 8'h00);
        preload(1'b1, 8'hFF, 8'h00);
        preload(1'b1, 8'h00, 8'h00);
        run_op(1'b0, 4'd8, 5'd3, 8'hFE, 0, b, da, sw, wn, cs);
        checks++; if (mem[8'hFE] !== 8'h01) begin errors++; $display("FAIL wrap_mem_fe got=%h exp=01", mem[8'hFE]); end
        checks++; if (mem[8'hFF] !== 8'h02) begin errors++; $display("FAIL wrap_mem_ff got=%h exp=02", mem[8'hFF]); end
        checks++; if (mem[8'h00] !== 8'h03) begin errors++; $display("FAIL wrap_mem_00 got=%h exp=03", mem[8'h00]); end
        checks++; if (da != 4) begin errors++; $display("FAIL wrap_done_cycle got=%0d exp=4", da); end
    endtask

    task automatic test_reset_mid();
        int b, da, sw, wn, wr0;
        logic [7:0] cs;
        for (int i = 0; i < 8; i++) begin
            preload(1'b0, 8'(i), 8'(8'hC0 + i));
            preload(1'b1, 8'(8'h10 + i), 8'h00);
        end
        @(posedge clk); #1;
        wr0 = mem_wr_cnt;
        dir = 1'b0; first_reg = 4'd0; count = 5'd8; base_addr = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_status got=%b%b exp=00", busy, done); end
        checks++; if ({rf_wr_en, mem_wr_en} !== 2'b00 || mem_addr !== 8'h00 || rf_rd_addr !== 4'h0 || mem_wr_dat !== 8'h00) begin errors++; $display("FAIL rstmid_outputs got=%b%b %h %h %h exp=0", rf_wr_en, mem_wr_en, mem_addr, rf_rd_addr, mem_wr_dat); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (mem_wr_cnt - wr0 != 2) begin errors++; $display("FAIL rstmid_writes got=%0d exp=2", mem_wr_cnt - wr0); end
        checks++; if (mem[8'h11] !== 8'hC1 || mem[8'h12] !== 8'h00) begin errors++; $display("FAIL rstmid_mem got=%h/%h exp=c1/00", mem[8'h11], mem[8'h12]); end
        run_op(1'b0, 4'd5, 5'd1, 8'h30, 0, b, da, sw, wn, cs);
        checks++; if (da != 2 || wn != 1 || mem[8'h30] !== 8'hC5) begin errors++; $display("FAIL rstmid_restart got=done%0d wr%0d mem%h exp=done2 wr1 memc5", da, wn, mem[8'h30]); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        dir = 1'b0; first_reg = 4'd1; count = 5'd1; base_addr = 8'h60; start = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_not_queued got=%b%b exp=00", busy, done); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_spill();
        test_fill_wrap();
        test_stall();
        test_count_zero();
        test_mem_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
